// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the byte-addressed data memory; B/H stores via read-modify-write.
// Latency: grant->ack 2 cycles (load, word store), 3 (sub-word store), 1 (error); one transaction in flight.
// Backpressure: requesters hold req until ack; the loser waits in IDLE. Optional: MISALIGN_TRAP_EN traps misaligned H/W.
module dmem_arbiter #(
    parameter int SIZE = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            we0,
    input  logic [2:0]      size0,
    input  logic [SIZE-1:0] addr0,
    input  logic [31:0]     wdata0,
    output logic [31:0]     rdata0,
    output logic            ack0,
    output logic            err0,
    input  logic            req1,
    input  logic            we1,
    input  logic [2:0]      size1,
    input  logic [SIZE-1:0] addr1,
    input  logic [31:0]     wdata1,
    output logic [31:0]     rdata1,
    output logic            ack1,
    output logic            err1,
    output logic [SIZE-1:0] mem_addr,
    output logic [31:0]     mem_dataW,
    input  logic [31:0]     mem_dataR,
    output logic            mem_memR,
    output logic            mem_memW
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    // Highest legal start address: the 4-byte access must fit inside memory.
    localparam logic [SIZE-1:0] ADDR_MAX = {{(SIZE-2){1'b1}}, 2'b00};

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            last_q, last_d;
    logic            we_q, we_d;
    logic [2:0]      size_q, size_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata0_q, rdata0_d;
    logic [31:0]     rdata1_q, rdata1_d;
    logic [31:0]     dataw_q, dataw_d;

    logic            sel;
    logic            sel_we;
    logic [2:0]      sel_size;
    logic [SIZE-1:0] sel_addr;
    logic [31:0]     sel_wdata;
    logic            bad_range;
    logic            bad_size;
    logic            misalign;

    function automatic logic [31:0] load_ext(input logic [2:0] sz, input logic [31:0] d);
        case (sz)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'b0, d[7:0]};
            3'b101:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] sz, input logic [31:0] d,
                                          input logic [31:0] w);
        case (sz[1:0])
            2'b00:   return {d[31:8], w[7:0]};
            2'b01:   return {d[31:16], w[15:0]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        sel       = (req0 && req1) ? ~last_q : req1;
        sel_we    = sel ? we1    : we0;
        sel_size  = sel ? size1  : size0;
        sel_addr  = sel ? addr1  : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
        bad_range = sel_addr > ADDR_MAX;
        bad_size  = (sel_size == 3'b011) || (sel_size == 3'b110) || (sel_size == 3'b111);
`ifdef MISALIGN_TRAP_EN
        misalign  = ((sel_size[1:0] == 2'b01) && sel_addr[0]) ||
                    ((sel_size == 3'b010) && (sel_addr[1:0] != 2'b00));
`else
        misalign  = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        dataw_d  = dataw_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = sel;
                    last_d  = sel;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = bad_range || bad_size || misalign;
                    dataw_d = sel_wdata;
                    if (bad_range || bad_size || misalign) begin
                        state_d = DONE;
                    end else if (sel_we && (sel_size == 3'b010)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // Stores reaching RD are sub-word: merge new bytes into the fetched word.
                if (we_q) begin
                    dataw_d = merge(size_q, mem_dataR, wdata_q);
                    state_d = WR;
                end else begin
                    if (gnt_q) begin
                        rdata1_d = load_ext(size_q, mem_dataR);
                    end else begin
                        rdata0_d = load_ext(size_q, mem_dataR);
                    end
                    state_d = DONE;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            size_q   <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
            dataw_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            dataw_q  <= dataw_d;
        end
    end

    // Strobes decode straight from the state flop so reset drops them immediately.
    assign mem_memR  = (state_q == RD);
    assign mem_memW  = (state_q == WR);
    assign mem_addr  = addr_q;
    assign mem_dataW = dataw_q;
    assign ack0      = (state_q == DONE) && !gnt_q;
    assign ack1      = (state_q == DONE) && gnt_q;
    assign err0      = ack0 && err_q;
    assign err1      = ack1 && err_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule
